// File: rtl/reg_check_pkg.sv
// reg_check_pkg: FSM state encoding and default parameter values for the register check monitor
package reg_check_pkg;
   typedef enum logic [1:0] {IDLE, COUNT, COMPARE, DONE} state_t;
   localparam int NUM_CH_DEF  = 5;
   localparam int DATA_W_DEF  = 32;
   localparam int CYCLE_W_DEF = 32;
endpackage

// File: rtl/reg_check_cmp.sv
// reg_check_cmp: single-channel registered comparator stage that accumulates per-channel mismatches
module reg_check_cmp #(
   parameter int NUM_CH = 5,
   parameter int DATA_W = 32,
   parameter int IDX_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clr,
   input  logic              en,
   input  logic [IDX_W-1:0]  idx,
   input  logic [DATA_W-1:0] act_v,
   input  logic [DATA_W-1:0] exp_v,
   input  logic              chk,
   output logic              hit,
   output logic [NUM_CH-1:0] fail_mask
);
   assign hit = en && chk && (act_v != exp_v);
   // Sticky mismatch bit for the channel currently selected by idx
   always_ff @(posedge clk or posedge reset)
      if (reset) fail_mask <= '0;
      else if (clr) fail_mask <= '0;
      else if (hit) fail_mask[idx] <= 1'b1;
endmodule

// File: rtl/reg_check_monitor.sv
// reg_check_monitor: snapshots channels at a chosen run cycle and compares them one per clock; REG_CHECK_TRACE_EN enables a simulation trace
module reg_check_monitor
   import reg_check_pkg::*;
#(
   parameter int NUM_CH  = NUM_CH_DEF,
   parameter int DATA_W  = DATA_W_DEF,
   parameter int CYCLE_W = CYCLE_W_DEF
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [CYCLE_W-1:0]       check_cycle,
   input  logic [31:0]              pc_in,
   input  logic [NUM_CH*DATA_W-1:0] ch_data,
   input  logic [NUM_CH*DATA_W-1:0] exp_data,
   input  logic [NUM_CH-1:0]        ch_mask,
   output logic                     busy,
   output logic                     done,
   output logic                     pass,
   output logic [NUM_CH-1:0]        fail_mask,
   output logic [CYCLE_W-1:0]       cycle_count,
   output logic [31:0]              pc_snap
);
   localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
   state_t state, state_nx;
   logic [IDX_W-1:0] idx;
   logic [NUM_CH*DATA_W-1:0] snap_data, snap_exp;
   logic [NUM_CH-1:0] snap_mask;
   logic [DATA_W-1:0] act_v, exp_v;
   logic snap, last, hit, launch;
   assign launch = (state == IDLE || state == DONE) && start;
   assign snap   = state == COUNT && (cycle_count == check_cycle || check_cycle == '0);
   assign last   = state == COMPARE && idx == IDX_W'(NUM_CH - 1);
   assign busy   = state == COUNT || state == COMPARE;
   assign done   = state == DONE;
   assign act_v  = snap_data[idx*DATA_W +: DATA_W];
   assign exp_v  = snap_exp[idx*DATA_W +: DATA_W];
   // State register
   always_ff @(posedge clk or posedge reset)
      if (reset) state <= IDLE;
      else state <= state_nx;
   // Next-state: start only counts when idle or finished
   always_comb begin
      state_nx = state;
      state_nx = launch ? COUNT : snap ? COMPARE : last ? DONE : state;
   end
   // Run counter, snapshot capture, compare index and final verdict
   always_ff @(posedge clk or posedge reset)
      if (reset) begin
         cycle_count <= '0;
         pc_snap     <= '0;
         pass        <= 1'b0;
         idx         <= '0;
         snap_data   <= '0;
         snap_exp    <= '0;
         snap_mask   <= '0;
      end else begin
         if (launch) begin
            cycle_count <= CYCLE_W'(1);
            pass        <= 1'b0;
         end else if (state == COUNT && ~&cycle_count) cycle_count <= cycle_count + 1'b1;
         if (snap) begin
            pc_snap   <= pc_in;
            snap_data <= ch_data;
            snap_exp  <= exp_data;
            snap_mask <= ch_mask;
            idx       <= '0;
         end else if (state == COMPARE) idx <= idx + 1'b1;
         if (last) pass <= (fail_mask == '0) && !hit;
      end
   reg_check_cmp #(.NUM_CH(NUM_CH), .DATA_W(DATA_W), .IDX_W(IDX_W)) u_cmp (
      .clk(clk), .reset(reset), .clr(snap), .en(state == COMPARE), .idx(idx),
      .act_v(act_v), .exp_v(exp_v), .chk(snap_mask[idx]), .hit(hit), .fail_mask(fail_mask)
   );
`ifdef REG_CHECK_TRACE_EN
   // Trace each checked compare step and the final verdict
   always @(posedge clk) begin
      if (!reset && state == COMPARE && snap_mask[idx])
         $display("reg_check ch %0d act %h exp %h %s", idx, act_v, exp_v, hit ? "MISMATCH" : "OK");
      if (!reset && last)
         $display("reg_check cycle %0d pc %h %s", cycle_count, pc_snap, ((fail_mask == '0) && !hit) ? "PASS" : "FAIL");
   end
`endif
endmodule

// File: tb/tb_reg_check_monitor.sv
// tb_reg_check_monitor: table-driven directed checks plus reset and restart sequences
module tb_reg_check_monitor;
   logic clk = 1'b0, reset, start;
   logic [31:0] check_cycle, pc_in;
   logic [159:0] ch_data, exp_data;
   logic [4:0] ch_mask;
   logic busy, done, pass;
   logic [4:0] fail_mask;
   logic [31:0] cycle_count, pc_snap;
   int checks = 0, errors = 0, e = 0;

   reg_check_monitor #(.NUM_CH(5), .DATA_W(32), .CYCLE_W(32)) dut (
      .clk(clk), .reset(reset), .start(start), .check_cycle(check_cycle), .pc_in(pc_in),
      .ch_data(ch_data), .exp_data(exp_data), .ch_mask(ch_mask), .busy(busy), .done(done),
      .pass(pass), .fail_mask(fail_mask), .cycle_count(cycle_count), .pc_snap(pc_snap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [31:0]  cc;
      logic [159:0] ch;
      logic [159:0] ex;
      logic [4:0]   mask;
      bit           chg;
      bit           pass;
      logic [4:0]   fm;
      int           lat;
      logic [31:0]  pc;
   } vec_t;
   vec_t tbl [6];

   function automatic logic [159:0] pack5(input int a, input int b, input int c, input int d, input int f);
      return {f[31:0], d[31:0], c[31:0], b[31:0], a[31:0]};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] want);
      checks++;
      if (act !== want) begin
         errors++;
         $display("FAIL %s: got %0h want %0h", name, act, want);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
      e++;
      pc_in = 32'h1000 + e + 1;
   endtask

   task automatic launch(input logic [31:0] cc, input logic [159:0] ch, input logic [159:0] ex, input logic [4:0] m);
      check_cycle = cc;
      ch_data = ch;
      exp_data = ex;
      ch_mask = m;
      start = 1'b1;
      e = -1;
      step();
      start = 1'b0;
   endtask

   task automatic wait_done();
      while (!done && e < 300) step();
   endtask

   initial begin
      tbl[0] = '{32'd12, pack5(15,10,3,25,28), pack5(15,10,3,25,28), 5'b11111, 0, 1, 5'b00000, 17, 32'h100C};
      tbl[1] = '{32'd12, pack5(15,10,3,24,28), pack5(15,10,3,25,28), 5'b11111, 0, 0, 5'b01000, 17, 32'h100C};
      tbl[2] = '{32'd12, pack5(15,10,3,24,28), pack5(15,10,3,25,28), 5'b10111, 0, 1, 5'b00000, 17, 32'h100C};
      tbl[3] = '{32'd12, pack5(15,10,3,25,28), pack5(15,10,3,25,28), 5'b11111, 1, 1, 5'b00000, 17, 32'h100C};
      tbl[4] = '{32'd1,  pack5(1,7,7,7,9),     pack5(2,7,7,7,8),     5'b11111, 0, 0, 5'b10001, 6,  32'h1001};
      tbl[5] = '{32'd0,  pack5(1,2,3,4,5),     pack5(6,7,8,9,10),    5'b00000, 0, 1, 5'b00000, 6,  32'h1001};
      reset = 1'b1;
      start = 1'b0;
      check_cycle = '0;
      pc_in = '0;
      ch_data = '0;
      exp_data = '0;
      ch_mask = '0;
      #12;
      chk("rst_busy", busy, 0);
      chk("rst_done", done, 0);
      chk("rst_pass", pass, 0);
      chk("rst_fm", fail_mask, 0);
      chk("rst_cc", cycle_count, 0);
      chk("rst_pc", pc_snap, 0);
      @(negedge clk);
      reset = 1'b0;
      for (int i = 0; i < 6; i++) begin
         launch(tbl[i].cc, tbl[i].ch, tbl[i].ex, tbl[i].mask);
         chk($sformatf("v%0d_cc1", i), cycle_count, 1);
         chk($sformatf("v%0d_busy", i), busy, 1);
         chk($sformatf("v%0d_done0", i), done, 0);
         while (!done && e < 300) begin
            step();
            if (tbl[i].chg && e == tbl[i].lat - 4) begin
               ch_data = ~ch_data;
               exp_data = pack5(1,1,1,1,1);
               ch_mask = 5'b01010;
               pc_in = 32'hDEAD;
            end
         end
         chk($sformatf("v%0d_lat", i), e, tbl[i].lat);
         chk($sformatf("v%0d_done", i), done, 1);
         chk($sformatf("v%0d_busy0", i), busy, 0);
         chk($sformatf("v%0d_pass", i), pass, tbl[i].pass);
         chk($sformatf("v%0d_fm", i), fail_mask, tbl[i].fm);
         chk($sformatf("v%0d_pc", i), pc_snap, tbl[i].pc);
         ch_data = ~ch_data;
         repeat (3) step();
         chk($sformatf("v%0d_hold_done", i), done, 1);
         chk($sformatf("v%0d_hold_pass", i), pass, tbl[i].pass);
         chk($sformatf("v%0d_hold_fm", i), fail_mask, tbl[i].fm);
         chk($sformatf("v%0d_hold_pc", i), pc_snap, tbl[i].pc);
      end
      launch(32'd12, pack5(1,2,3,4,5), pack5(1,2,3,4,9), 5'b11111);
      while (e < 14) step();
      chk("mid_busy", busy, 1);
      #2 reset = 1'b1;
      #1;
      chk("mr_busy", busy, 0);
      chk("mr_done", done, 0);
      chk("mr_pass", pass, 0);
      chk("mr_fm", fail_mask, 0);
      chk("mr_cc", cycle_count, 0);
      chk("mr_pc", pc_snap, 0);
      step();
      chk("mr_hold_cc", cycle_count, 0);
      chk("mr_hold_busy", busy, 0);
      reset = 1'b0;
      begin
         int seen = 0;
         repeat (25) begin
            step();
            if (done || busy) seen++;
         end
         chk("mr_no_done", seen, 0);
      end
      launch(32'd0, pack5(4,4,4,4,4), pack5(4,4,4,4,4), 5'b11111);
      chk("cc0_cc1", cycle_count, 1);
      wait_done();
      chk("cc0_lat", e, 6);
      chk("cc0_pass", pass, 1);
      chk("cc0_pc", pc_snap, 32'h1001);
      launch(32'd12, pack5(15,10,3,25,28), pack5(15,10,3,25,28), 5'b11111);
      repeat (3) step();
      start = 1'b1;
      step();
      start = 1'b0;
      chk("ign_cc", cycle_count, 5);
      wait_done();
      chk("ign_lat", e, 17);
      chk("ign_pass", pass, 1);
      launch(32'd12, pack5(15,10,3,24,28), pack5(15,10,3,25,28), 5'b11111);
      chk("rs_cc", cycle_count, 1);
      chk("rs_done", done, 0);
      chk("rs_busy", busy, 1);
      wait_done();
      chk("rs_lat", e, 17);
      chk("rs_pass", pass, 0);
      chk("rs_fm", fail_mask, 5'b01000);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
